// File: rtl/wb_event_dma_master_if.sv
// Wishbone classic bus between the event DMA initiator and the PCI bridge slave port.
// Signal names keep the initiator-side view so they line up with the WBS_* wiring.
interface wb_event_dma_master_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cab_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cab_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cab_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface

// File: rtl/wb_event_dma_master.sv
// Event DMA initiator: buffers trigger words in a FIFO and writes each one into a host
// memory ring with single classic Wishbone write cycles, raising irq_o while the ring holds data.
module wb_event_dma_master #(
    parameter int FIFO_AW = 4,
    parameter int RING_AW = 10,
    parameter int TIMEOUT = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               enable_i,
    input  logic [31:0]        ring_base_i,
    input  logic [RING_AW-1:0] rd_ptr_i,
    output logic [RING_AW-1:0] wr_ptr_o,
    input  logic               evt_valid_i,
    input  logic [31:0]        evt_data_i,
    output logic               evt_ready_o,
    wb_event_dma_master_if.master wbm,
    output logic               irq_o,
    output logic               err_o,
    output logic [15:0]        retry_cnt_o
);

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [RING_AW-1:0] RING_ONE = RING_AW'(1);
    localparam logic [7:0]         TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, XFER, BACKOFF, HALT} state_t;

    state_t state;

    // Event FIFO
    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] fifo_wr_idx;
    logic [FIFO_AW-1:0] fifo_rd_idx;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               ready_en;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [31:0]        head;

    // Bus side registers
    logic        cyc_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [7:0]  tmo_cnt;
    logic        ring_full;
    logic        start;

    assign fifo_full   = (fifo_cnt == CNT_FULL);
    assign fifo_empty  = (fifo_cnt == '0);
    assign evt_ready_o = ready_en & ~fifo_full;
    assign push        = evt_valid_i & evt_ready_o;
    assign pop         = (state == XFER) & wbm.wbm_ack_i & ~wbm.wbm_err_i & ~wbm.wbm_rty_i;
    assign head        = mem[fifo_rd_idx];

    // NOTE: the storage array has no reset; the pointers and count alone define its contents.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[fifo_wr_idx] <= evt_data_i;
        end
    end

    // NOTE: every register updated on the clock uses <= so all readers see pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            fifo_wr_idx <= '0;
            fifo_rd_idx <= '0;
            fifo_cnt    <= '0;
            ready_en    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                fifo_wr_idx <= fifo_wr_idx + 1'b1;
            end
            if (pop) begin
                fifo_rd_idx <= fifo_rd_idx + 1'b1;
            end
            fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    // One ring slot stays empty so that wr_ptr == rd_ptr always means "ring empty".
    assign ring_full = ((wr_ptr_o + RING_ONE) == rd_ptr_i);
    assign start     = enable_i & ~fifo_empty & ~ring_full & ~err_o;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state       <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= '0;
            dat_q       <= '0;
            tmo_cnt     <= '0;
            wr_ptr_o    <= '0;
            err_o       <= 1'b0;
            retry_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= XFER;
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b1;
                        sel_q   <= 4'hF;
                        adr_q   <= ring_base_i + (32'(wr_ptr_o) << 2);
                        dat_q   <= head;
                        tmo_cnt <= '0;
                    end
                end
                XFER: begin
                    // err outranks rty, which outranks ack, when several arrive together.
                    if (wbm.wbm_err_i || tmo_cnt == TMO_LAST) begin
                        state <= HALT;
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                        sel_q <= 4'h0;
                        err_o <= 1'b1;
                    end else if (wbm.wbm_rty_i) begin
                        state <= BACKOFF;
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                        sel_q <= 4'h0;
                        if (retry_cnt_o != 16'hFFFF) begin
                            retry_cnt_o <= retry_cnt_o + 16'd1;
                        end
                    end else if (wbm.wbm_ack_i) begin
                        state    <= IDLE;
                        cyc_q    <= 1'b0;
                        we_q     <= 1'b0;
                        sel_q    <= 4'h0;
                        wr_ptr_o <= wr_ptr_o + RING_ONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                BACKOFF: begin
                    state <= IDLE;
                end
                HALT: begin
                    if (!enable_i) begin
                        state <= IDLE;
                        err_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_cab_o = 1'b0;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;

    assign irq_o = enable_i & (wr_ptr_o != rd_ptr_i);

endmodule
